// File: rtl/keypad_encoder.sv
// keypad_encoder
//   Debounced 10-key keypad encoder with a ready/valid digit output.
//   The raw active-low key lines are synchronized, priority encoded
//   (highest index wins), debounced on press and release, and each accepted
//   press is offered exactly once as a BCD digit.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable samples to accept a press/release (1..255)
//
// Ports
//   CLK    in   clock, rising edge
//   CLRb   in   synchronous active-low reset
//   KEYn   in   [9:0] raw asynchronous key lines, active-low, bit k = digit k
//   RDY    in   consumer accepts the digit this cycle
//   VALID  out  DIGIT holds an accepted, unconsumed key code
//   DIGIT  out  [3:0] BCD code of the accepted key
//   BUSY   out  FSM is in any state other than IDLE
//   ERR    out  multi-key error flag
//
// Configuration
//   KEYPAD_MULTI_ERR_EN  when defined, a multi-key press during press debounce
//                        raises ERR and delivers no digit; otherwise multi-key
//                        presses resolve by priority and ERR is tied low.

module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       CLRb,
  input  logic [9:0] KEYn,
  input  logic       RDY,
  output logic       VALID,
  output logic [3:0] DIGIT,
  output logic       BUSY,
  output logic       ERR
);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    OFFER,
    HELD,
    DEB_REL
  } state_t;

  localparam logic [8:0] DEB_LIM = 9'(DEBOUNCE_CYCLES);

  state_t     state;
  logic [9:0] sync1;
  logic [9:0] keys;
  logic [7:0] counter;
  logic [3:0] cand;

  logic [3:0] code;
  logic       pressed;
  logic [8:0] cnt_inc;
  logic       cnt_done;

  // Highest index wins: later iterations override earlier ones.
  always_comb begin
    code = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (!keys[i]) code = 4'(i);
    end
  end

  assign pressed  = ~&keys;
  // Widened so the compare is exact and the counter can saturate instead of wrap.
  assign cnt_inc  = {1'b0, counter} + 9'd1;
  assign cnt_done = (cnt_inc >= DEB_LIM);

`ifdef KEYPAD_MULTI_ERR_EN
  logic       err_q;
  logic [9:0] act;
  logic       multi;

  assign act   = ~keys;
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi = |(act & (act - 10'd1));
  assign ERR   = err_q;
`else
  assign ERR   = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!CLRb) begin
      state   <= IDLE;
      sync1   <= '1;
      keys    <= '1;
      counter <= '0;
      cand    <= '0;
      VALID   <= 1'b0;
      DIGIT   <= '0;
      BUSY    <= 1'b0;
`ifdef KEYPAD_MULTI_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      sync1 <= KEYn;
      keys  <= sync1;
      case (state)
        IDLE: begin
          if (pressed) begin
            cand    <= code;
            counter <= 8'd1;
            state   <= DEB_PRESS;
            BUSY    <= 1'b1;
          end
        end

        DEB_PRESS: begin
`ifdef KEYPAD_MULTI_ERR_EN
          if (pressed && multi) begin
            err_q <= 1'b1;
            state <= HELD;
          end else
`endif
          if (!pressed) begin
            state <= IDLE;
            BUSY  <= 1'b0;
`ifdef KEYPAD_MULTI_ERR_EN
            err_q <= 1'b0;
`endif
          end else if (code != cand) begin
            cand    <= code;
            counter <= 8'd1;
          end else if (cnt_done) begin
            counter <= DEB_LIM[7:0];
            DIGIT   <= cand;
            VALID   <= 1'b1;
            state   <= OFFER;
          end else begin
            counter <= cnt_inc[7:0];
          end
        end

        OFFER: begin
          if (RDY) begin
            VALID <= 1'b0;
            if (pressed) begin
              state <= HELD;
            end else begin
              counter <= 8'd1;
              state   <= DEB_REL;
            end
          end
        end

        HELD: begin
          if (!pressed) begin
            counter <= 8'd1;
            state   <= DEB_REL;
          end
        end

        DEB_REL: begin
          if (pressed) begin
            state <= HELD;
          end else if (cnt_done) begin
            counter <= DEB_LIM[7:0];
            state   <= IDLE;
            BUSY    <= 1'b0;
`ifdef KEYPAD_MULTI_ERR_EN
            err_q   <= 1'b0;
`endif
          end else begin
            counter <= cnt_inc[7:0];
          end
        end

        default: begin
          state <= IDLE;
          VALID <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
